// File: rtl/seg7_mmio_responder.sv
// Memory-mapped driver for an 8-digit multiplexed 7-segment display.
// The CPU writes hex digits and a digit mask; the block scans one digit at a time.
module seg7_mmio_responder #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_F000,
  parameter int          SCAN_DIV  = 20000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [7:0]  led_en_o,
  output logic [7:0]  led_seg_o
);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_CTRL   = 2'd1,
    REG_STATUS = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_t;

  localparam logic [19:0] PRESC_LAST = 20'(SCAN_DIV - 1);

  logic [31:0] data_q;
  logic [7:0]  mask_q;
  logic        blank_q;
  logic [19:0] presc_q;
  logic [2:0]  idx_q;

  logic [31:0] offset;
  logic        in_window;
  reg_sel_t    sel;
  logic        data_we;
  logic        ctrl_we;
  logic        scan_wrap;
  logic        digit_on;
  logic [3:0]  nibble;
  logic        unused_byte_lanes;

  // Unsigned subtraction makes addresses below the base wrap far out of the window.
  assign offset            = addr_i - BASE_ADDR;
  assign in_window         = (offset[31:4] == 28'd0);
  assign sel               = reg_sel_t'(offset[3:2]);
  assign unused_byte_lanes = ^offset[1:0];

  assign data_we   = we_i && in_window && (sel == REG_DATA);
  assign ctrl_we   = we_i && in_window && (sel == REG_CTRL);
  assign scan_wrap = (presc_q == PRESC_LAST);
  assign digit_on  = !blank_q && mask_q[idx_q];
  assign nibble    = data_q[{idx_q, 2'b00} +: 4];

  function automatic logic [7:0] seg_decode(input logic [3:0] value);
    case (value)
      4'h0: seg_decode = 8'hC0;
      4'h1: seg_decode = 8'hF9;
      4'h2: seg_decode = 8'hA4;
      4'h3: seg_decode = 8'hB0;
      4'h4: seg_decode = 8'h99;
      4'h5: seg_decode = 8'h92;
      4'h6: seg_decode = 8'h82;
      4'h7: seg_decode = 8'hF8;
      4'h8: seg_decode = 8'h80;
      4'h9: seg_decode = 8'h90;
      4'hA: seg_decode = 8'h88;
      4'hB: seg_decode = 8'h83;
      4'hC: seg_decode = 8'hC6;
      4'hD: seg_decode = 8'hA1;
      4'hE: seg_decode = 8'h86;
      default: seg_decode = 8'h8E;
    endcase
  endfunction

  always_comb begin
    // NOTE: default assignment first, so no path leaves rdata_o unassigned (no latch).
    rdata_o = 32'h0;
    if (in_window) begin
      case (sel)
        REG_DATA:   rdata_o = data_q;
        REG_CTRL:   rdata_o = {23'h0, blank_q, mask_q};
        REG_STATUS: rdata_o = {29'h0, idx_q};
        default:    rdata_o = 32'h0;
      endcase
    end
  end

  // Outputs are computed from pre-edge state, so an index or register change
  // reaches the display pins one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q    <= 32'h0;
      mask_q    <= 8'hFF;
      blank_q   <= 1'b0;
      presc_q   <= 20'd0;
      idx_q     <= 3'd0;
      led_en_o  <= 8'hFF;
      led_seg_o <= 8'hFF;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      presc_q <= scan_wrap ? 20'd0 : presc_q + 20'd1;
      if (scan_wrap) idx_q <= idx_q + 3'd1;
      if (data_we) data_q <= wdata_i;
      if (ctrl_we) begin
        mask_q  <= wdata_i[7:0];
        blank_q <= wdata_i[8];
      end
      led_en_o  <= digit_on ? ~(8'b1 << idx_q) : 8'hFF;
      led_seg_o <= seg_decode(nibble);
    end
  end

endmodule

// File: tb/tb_seg7_mmio_responder.sv
// Self-checking bench for seg7_mmio_responder with SCAN_DIV=4.
// Expected display outputs are queued per clock edge and compared as the DUT produces them.
module tb_seg7_mmio_responder;

  localparam logic [31:0] BASE = 32'hFFFF_F000;
  localparam int          DIV  = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic [7:0]  led_en_o;
  logic [7:0]  led_seg_o;

  typedef struct packed {
    logic [7:0] en;
    logic [7:0] seg;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  seg_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int          n_pass  = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  seg7_mmio_responder #(.BASE_ADDR(BASE), .SCAN_DIV(DIV)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .wdata_i  (wdata_i),
    .rdata_o  (rdata_o),
    .led_en_o (led_en_o),
    .led_seg_o(led_seg_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after the reset edge with rst_i low (edge count k = 0).
  task automatic do_reset();
    we_i  = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr_i  = a;
    wdata_i = d;
    we_i    = 1'b1;
    tick();
    we_i    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr_i = a;
    #1;
    d = rdata_o;
  endtask

  // Display expected after post-release edge k: digit index advances every DIV edges,
  // and the pins lag the index by one edge.
  function automatic exp_t scan_exp(input int k, input logic [31:0] data,
                                    input logic [7:0] mask, input logic blank);
    int d;
    logic [3:0] nib;
    d   = ((k - 1) / DIV) % 8;
    nib = data[d*4 +: 4];
    scan_exp.en  = (!blank && mask[d]) ? ~(8'b1 << d) : 8'hFF;
    scan_exp.seg = seg_lut[nib];
  endfunction

  task automatic test_reset();
    logic [31:0] rd;
    rst_i = 1'b1; we_i = 1'b0; addr_i = BASE; wdata_i = 32'h0;
    tick();
    n_total++;
    if ({led_en_o, led_seg_o} !== 16'hFFFF)
      $display("FAIL reset_outputs: got en=%h seg=%h expected en=ff seg=ff", led_en_o, led_seg_o);
    else n_pass++;
    bus_read(BASE + 32'h4, rd);
    n_total++;
    if (rd !== 32'h0000_00FF) $display("FAIL reset_ctrl: got %h expected 000000ff", rd);
    else n_pass++;
    bus_read(BASE + 32'h8, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL reset_status: got %h expected 00000000", rd);
    else n_pass++;
    bus_read(BASE, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL reset_data: got %h expected 00000000", rd);
    else n_pass++;
    rst_i = 1'b0;
    tick();
    n_total++;
    if ({led_en_o, led_seg_o} !== 16'hFEC0)
      $display("FAIL release_outputs: got en=%h seg=%h expected en=fe seg=c0", led_en_o, led_seg_o);
    else n_pass++;
  endtask

  task automatic test_scan();
    logic [31:0] rd;
    exp_t e;
    do_reset();
    addr_i = BASE; wdata_i = 32'h89AB_CDEF; we_i = 1'b1;
    #1;
    n_total++;
    if (rdata_o !== 32'h0) $display("FAIL write_same_cycle: got %h expected 00000000", rdata_o);
    else n_pass++;
    tick();
    we_i = 1'b0;
    n_total++;
    if ({led_en_o, led_seg_o} !== 16'hFEC0)
      $display("FAIL scan_old_data: got en=%h seg=%h expected en=fe seg=c0", led_en_o, led_seg_o);
    else n_pass++;
    bus_read(BASE, rd);
    n_total++;
    if (rd !== 32'h89AB_CDEF) $display("FAIL data_readback: got %h expected 89abcdef", rd);
    else n_pass++;
    for (int k = 2; k <= 37; k++) sb.push_back(scan_exp(k, 32'h89AB_CDEF, 8'hFF, 1'b0));
    for (int k = 2; sb.size() > 0; k++) begin
      tick();
      e = sb.pop_front();
      n_total++;
      if ({led_en_o, led_seg_o} !== e)
        $display("FAIL scan_edge_%0d: got en=%h seg=%h expected en=%h seg=%h",
                 k, led_en_o, led_seg_o, e.en, e.seg);
      else n_pass++;
    end
  endtask

  task automatic test_mask();
    logic [31:0] rd;
    exp_t e;
    do_reset();
    bus_write(BASE + 32'h4, 32'h0000_00F5);
    n_total++;
    if ({led_en_o, led_seg_o} !== 16'hFEC0)
      $display("FAIL mask_old_ctrl: got en=%h seg=%h expected en=fe seg=c0", led_en_o, led_seg_o);
    else n_pass++;
    bus_read(BASE + 32'h4, rd);
    n_total++;
    if (rd !== 32'h0000_00F5) $display("FAIL ctrl_readback: got %h expected 000000f5", rd);
    else n_pass++;
    for (int k = 2; k <= 33; k++) sb.push_back(scan_exp(k, 32'h0, 8'hF5, 1'b0));
    for (int k = 2; sb.size() > 0; k++) begin
      tick();
      e = sb.pop_front();
      n_total++;
      if ({led_en_o, led_seg_o} !== e)
        $display("FAIL mask_edge_%0d: got en=%h seg=%h expected en=%h seg=%h",
                 k, led_en_o, led_seg_o, e.en, e.seg);
      else n_pass++;
    end
    bus_write(BASE + 32'h4, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h4, rd);
    n_total++;
    if (rd !== 32'h0000_01FF) $display("FAIL ctrl_upper_bits: got %h expected 000001ff", rd);
    else n_pass++;
    for (int k = 35; k <= 42; k++) sb.push_back(scan_exp(k, 32'h0, 8'hFF, 1'b1));
    for (int k = 35; sb.size() > 0; k++) begin
      tick();
      e = sb.pop_front();
      n_total++;
      if ({led_en_o, led_seg_o} !== e)
        $display("FAIL blank_edge_%0d: got en=%h seg=%h expected en=%h seg=%h",
                 k, led_en_o, led_seg_o, e.en, e.seg);
      else n_pass++;
    end
  endtask

  task automatic test_bus_ignore();
    logic [31:0] rd;
    do_reset();
    bus_write(BASE,          32'h1234_5678);
    bus_write(BASE + 32'h8,  32'hFFFF_FFFF);
    bus_write(BASE + 32'hC,  32'hFFFF_FFFF);
    bus_write(BASE + 32'h10, 32'hFFFF_FFFF);
    bus_write(BASE - 32'h4,  32'hFFFF_FFFF);
    n_total++;
    if ({led_en_o, led_seg_o} !== 16'hFDF8)
      $display("FAIL ignore_outputs: got en=%h seg=%h expected en=fd seg=f8", led_en_o, led_seg_o);
    else n_pass++;
    bus_read(BASE, rd);
    n_total++;
    if (rd !== 32'h1234_5678) $display("FAIL ignore_data: got %h expected 12345678", rd);
    else n_pass++;
    bus_read(BASE + 32'h1, rd);
    n_total++;
    if (rd !== 32'h1234_5678) $display("FAIL unaligned_data: got %h expected 12345678", rd);
    else n_pass++;
    bus_read(BASE + 32'h4, rd);
    n_total++;
    if (rd !== 32'h0000_00FF) $display("FAIL ignore_ctrl: got %h expected 000000ff", rd);
    else n_pass++;
    bus_read(BASE + 32'h8, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL ignore_status: got %h expected 00000001", rd);
    else n_pass++;
    bus_read(BASE + 32'hC, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL reserved_read: got %h expected 00000000", rd);
    else n_pass++;
    bus_read(BASE + 32'h10, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL above_window_read: got %h expected 00000000", rd);
    else n_pass++;
    bus_read(BASE - 32'h4, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL below_window_read: got %h expected 00000000", rd);
    else n_pass++;
    repeat (3) tick();
    bus_read(BASE + 32'h8, rd);
    n_total++;
    if (rd !== 32'h2) $display("FAIL status_advance: got %h expected 00000002", rd);
    else n_pass++;
  endtask

  task automatic test_advance_write();
    logic [31:0] rd;
    do_reset();
    repeat (3) tick();
    bus_write(BASE, 32'h0000_00A0);
    n_total++;
    if ({led_en_o, led_seg_o} !== 16'hFEC0)
      $display("FAIL advance_edge: got en=%h seg=%h expected en=fe seg=c0", led_en_o, led_seg_o);
    else n_pass++;
    bus_read(BASE + 32'h8, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL advance_status: got %h expected 00000001", rd);
    else n_pass++;
    tick();
    n_total++;
    if ({led_en_o, led_seg_o} !== 16'hFD88)
      $display("FAIL advance_new_nibble: got en=%h seg=%h expected en=fd seg=88", led_en_o, led_seg_o);
    else n_pass++;
    repeat (6) tick();
    rst_i = 1'b1; addr_i = BASE; wdata_i = 32'hFFFF_FFFF; we_i = 1'b1;
    tick();
    n_total++;
    if ({led_en_o, led_seg_o} !== 16'hFFFF)
      $display("FAIL midscan_reset: got en=%h seg=%h expected en=ff seg=ff", led_en_o, led_seg_o);
    else n_pass++;
    we_i = 1'b0;
    bus_read(BASE, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL reset_beats_write: got %h expected 00000000", rd);
    else n_pass++;
    bus_read(BASE + 32'h8, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL midscan_status: got %h expected 00000000", rd);
    else n_pass++;
    rst_i = 1'b0;
    tick();
    n_total++;
    if ({led_en_o, led_seg_o} !== 16'hFEC0)
      $display("FAIL rerelease_outputs: got en=%h seg=%h expected en=fe seg=c0", led_en_o, led_seg_o);
    else n_pass++;
  endtask

  initial begin
    rst_i = 1'b1; we_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
    test_reset();
    test_scan();
    test_mask();
    test_bus_ignore();
    test_advance_write();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
